// File: rtl/scan_ctrl_pkg.sv
// Shared FSM encoding and byte-level constants for the scan-chain configuration controller.
package scan_ctrl_pkg;

  localparam int BYTE_W = 8;
  localparam int IDX_W  = 3;
  localparam int LEN_W  = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SHIFT = 3'd2,
    DRAIN = 3'd3,
    FIN   = 3'd4
  } state_t;

endpackage

// File: rtl/scan_serdes.sv
// Byte serializer/deserializer for the scan chain: drives the chain head LSB-first
// and captures the chain tail, stopping after a programmable number of bits.
module scan_serdes
  import scan_ctrl_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clear,
  input  logic              i_load,
  input  logic [BYTE_W-1:0] i_data,
  input  logic [LEN_W-1:0]  i_len,
  input  logic              i_shift,
  input  logic              i_tail,
  output logic              o_head,
  output logic [BYTE_W-1:0] o_rb,
  output logic              o_last
);

  logic [BYTE_W-1:0] r_piso;
  logic [BYTE_W-1:0] r_sipo;
  logic [IDX_W-1:0]  r_idx;

  assign o_last = (LEN_W'(r_idx) == (i_len - LEN_W'(1)));

  // The head bit flushes to zero after the final shift so the chain sees a quiet input between bytes.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_piso <= '0;
      r_sipo <= '0;
      r_idx  <= '0;
    end else if (i_clear) begin
      r_piso <= '0;
      r_sipo <= '0;
      r_idx  <= '0;
    end else if (i_load) begin
      r_piso <= i_data;
      r_sipo <= '0;
      r_idx  <= '0;
    end else if (i_shift) begin
      r_sipo[r_idx] <= i_tail;
      r_piso        <= o_last ? '0 : (r_piso >> 1);
      r_idx         <= r_idx + IDX_W'(1);
    end
  end

  assign o_head = r_piso[0];
  assign o_rb   = r_sipo;

endmodule

// File: rtl/scan_config_ctrl.sv
// Loads the overlay configuration scan chain from a byte stream and returns
// the displaced chain contents as readback bytes.
module scan_config_ctrl
  import scan_ctrl_pkg::*;
#(
  parameter int CHAIN_LEN = 1024
) (
  input  logic              i_sclk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic              i_cmd_valid,
  input  logic [BYTE_W-1:0] i_cmd_data,
  output logic              o_cmd_ready,
  output logic              o_rb_valid,
  output logic [BYTE_W-1:0] o_rb_data,
  input  logic              i_rb_ready,
  output logic              o_shift_head,
  input  logic              i_shift_tail,
  output logic              o_shift_enable,
  output logic              o_busy,
  output logic              o_done
);

  localparam int CW = $clog2(CHAIN_LEN + 1);

  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_count;
  logic [LEN_W-1:0] r_k;
  logic [LEN_W-1:0] w_k;
  int               w_rem;

  logic r_cmd_ready, r_rb_valid, r_shift_enable, r_busy, r_done;
  logic w_cmd_ready_d, w_rb_valid_d, w_shift_enable_d, w_busy_d, w_done_d;
  logic w_cmd_hs, w_rb_hs, w_ser_last, w_last, w_shifting, w_idle_like;

  assign w_cmd_hs    = r_cmd_ready & i_cmd_valid;
  assign w_rb_hs     = r_rb_valid & i_rb_ready;
  assign w_shifting  = (r_state == SHIFT);
  assign w_last      = w_shifting & w_ser_last;
  assign w_idle_like = (r_state == IDLE) || (r_state == FIN);

  // Last byte of the chain may be short: shift only the bits still missing.
  always_comb begin
    w_rem = CHAIN_LEN - int'(r_count);
    w_k   = (w_rem >= 8) ? LEN_W'(8) : LEN_W'(w_rem);
  end

  always_ff @(posedge i_sclk or posedge i_reset) begin
    if (i_reset) begin
      r_state        <= IDLE;
      r_cmd_ready    <= 1'b0;
      r_rb_valid     <= 1'b0;
      r_shift_enable <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
    end else begin
      r_state        <= w_next;
      r_cmd_ready    <= w_cmd_ready_d;
      r_rb_valid     <= w_rb_valid_d;
      r_shift_enable <= w_shift_enable_d;
      r_busy         <= w_busy_d;
      r_done         <= w_done_d;
    end
  end

  always_comb begin
    w_next = r_state;
    if (i_abort) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE, FIN: if (i_start) w_next = LOAD;
        LOAD:      if (w_cmd_hs) w_next = SHIFT;
        SHIFT:     if (w_last) w_next = DRAIN;
        DRAIN:     if (w_rb_hs) w_next = (r_count == CW'(CHAIN_LEN)) ? FIN : LOAD;
        default:   w_next = IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state so each one is a clean flop output.
  always_comb begin
    w_cmd_ready_d    = (w_next == LOAD);
    w_rb_valid_d     = (w_next == DRAIN);
    w_shift_enable_d = (w_next == SHIFT);
    w_busy_d         = (w_next == LOAD) || (w_next == SHIFT) || (w_next == DRAIN);
    w_done_d         = (w_next == FIN);
  end

  always_ff @(posedge i_sclk or posedge i_reset) begin
    if (i_reset) begin
      r_count <= '0;
      r_k     <= '0;
    end else if (!i_abort) begin
      if (w_idle_like && i_start) begin
        r_count <= '0;
      end else if (w_cmd_hs) begin
        r_k <= w_k;
      end else if (w_last) begin
        r_count <= r_count + CW'(r_k);
      end
    end
  end

  scan_serdes u_serdes (
    .i_clk   (i_sclk),
    .i_rst   (i_reset),
    .i_clear (i_abort),
    .i_load  (w_cmd_hs),
    .i_data  (i_cmd_data),
    .i_len   (r_k),
    .i_shift (w_shifting),
    .i_tail  (i_shift_tail),
    .o_head  (o_shift_head),
    .o_rb    (o_rb_data),
    .o_last  (w_ser_last)
  );

  assign o_cmd_ready    = r_cmd_ready;
  assign o_rb_valid     = r_rb_valid;
  assign o_shift_enable = r_shift_enable;
  assign o_busy         = r_busy;
  assign o_done         = r_done;

endmodule

// File: tb/tb_scan_config_ctrl.sv
// Directed bench: a 16-bit and a 12-bit controller each drive a behavioural scan chain
// (shift toward bit 0, tail = bit 0); sel picks which instance the stimulus targets.
module tb_scan_config_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, abort = 1'b0, cmd_valid = 1'b0, rb_ready = 1'b0;
  logic sel = 1'b0, cnt_clr = 1'b0;
  logic [7:0] cmd_data = 8'h00;

  int checks = 0;
  int errors = 0;

  logic cr_a, rbv_a, head_a, en_a, busy_a, done_a, tail_a;
  logic cr_b, rbv_b, head_b, en_b, busy_b, done_b, tail_b;
  logic [7:0] rbd_a, rbd_b;
  logic [15:0] chain_a = 16'h0000;
  logic [11:0] chain_b = 12'hABC;

  logic cmd_ready, rb_valid, head, en, busy, done;
  logic [7:0] rb_data;

  int n;
  logic ok;
  logic [7:0] rb0, rb1;
  int en_cnt = 0;
  logic [15:0] head_log = 16'h0000;

  always #5 clk = ~clk;

  scan_config_ctrl #(.CHAIN_LEN(16)) dut_a (
    .i_sclk(clk), .i_reset(rst), .i_start(start & ~sel), .i_abort(abort & ~sel),
    .i_cmd_valid(cmd_valid & ~sel), .i_cmd_data(cmd_data), .o_cmd_ready(cr_a),
    .o_rb_valid(rbv_a), .o_rb_data(rbd_a), .i_rb_ready(rb_ready & ~sel),
    .o_shift_head(head_a), .i_shift_tail(tail_a), .o_shift_enable(en_a),
    .o_busy(busy_a), .o_done(done_a)
  );

  scan_config_ctrl #(.CHAIN_LEN(12)) dut_b (
    .i_sclk(clk), .i_reset(rst), .i_start(start & sel), .i_abort(abort & sel),
    .i_cmd_valid(cmd_valid & sel), .i_cmd_data(cmd_data), .o_cmd_ready(cr_b),
    .o_rb_valid(rbv_b), .o_rb_data(rbd_b), .i_rb_ready(rb_ready & sel),
    .o_shift_head(head_b), .i_shift_tail(tail_b), .o_shift_enable(en_b),
    .o_busy(busy_b), .o_done(done_b)
  );

  always @(posedge clk) if (en_a) chain_a <= {head_a, chain_a[15:1]};
  always @(posedge clk) if (en_b) chain_b <= {head_b, chain_b[11:1]};
  assign tail_a = chain_a[0];
  assign tail_b = chain_b[0];

  assign cmd_ready = sel ? cr_b   : cr_a;
  assign rb_valid  = sel ? rbv_b  : rbv_a;
  assign rb_data   = sel ? rbd_b  : rbd_a;
  assign head      = sel ? head_b : head_a;
  assign en        = sel ? en_b   : en_a;
  assign busy      = sel ? busy_b : busy_a;
  assign done      = sel ? done_b : done_a;

  // Enable count and head history of the selected instance; first head bit ends in bit 0.
  always @(posedge clk) begin
    if (cnt_clr) en_cnt <= 0;
    else if (en) en_cnt <= en_cnt + 1;
    if (en) head_log <= {head, head_log[15:1]};
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clearCount();
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
  endtask

  task automatic doStart();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] d);
    int k;
    k = 0;
    cmd_valid = 1'b1;
    cmd_data  = d;
    while (!cmd_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    checkOutput("cmd_accept_timeout", k < 50, 1);
    checkOutput("first_shift_latency", en, 1);
  endtask

  task automatic recvRb(output logic [7:0] d);
    int k;
    k = 0;
    rb_ready = 1'b1;
    while (!rb_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    d = rb_data;
    @(negedge clk);
    rb_ready = 1'b0;
    checkOutput("rb_timeout", k < 50, 1);
  endtask

  task automatic doLoad(input logic [7:0] b0, input logic [7:0] b1,
                        output logic [7:0] r0, output logic [7:0] r1);
    doStart();
    sendByte(b0);
    recvRb(r0);
    sendByte(b1);
    recvRb(r1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed no completion, expected finish before 100000 ns");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (2) @(negedge clk);
    checkOutput("rst_cmd_ready", cmd_ready, 0);
    checkOutput("rst_rb_valid", rb_valid, 0);
    checkOutput("rst_rb_data", rb_data, 0);
    checkOutput("rst_head", head, 0);
    checkOutput("rst_enable", en, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    rst = 1'b0;
    @(negedge clk);

    // Test 1: first load of 0xA5,0x3C into a zeroed 16-bit chain
    clearCount();
    doStart();
    checkOutput("t1_busy", busy, 1);
    checkOutput("t1_cmd_ready", cmd_ready, 1);
    sendByte(8'hA5);
    repeat (7) @(negedge clk);
    checkOutput("t1_last_shift_en", en, 1);
    checkOutput("t1_rb_not_yet", rb_valid, 0);
    @(negedge clk);
    checkOutput("t1_shift_end", en, 0);
    checkOutput("t1_rb_valid", rb_valid, 1);
    checkOutput("t1_no_ready_in_drain", cmd_ready, 0);
    recvRb(rb0);
    sendByte(8'h3C);
    recvRb(rb1);
    checkOutput("t1_rb0", rb0, 8'h00);
    checkOutput("t1_rb1", rb1, 8'h00);
    checkOutput("t1_enable_count", en_cnt, 16);
    checkOutput("t1_head_seq", head_log, 16'h3CA5);
    checkOutput("t1_done", done, 1);
    checkOutput("t1_busy_low", busy, 0);
    checkOutput("t1_chain", chain_a, 16'h3CA5);
    checkOutput("t1_fin_no_ready", cmd_ready, 0);

    // Test 2: reload reads back the previous contents
    clearCount();
    doStart();
    checkOutput("t2_done_cleared", done, 0);
    checkOutput("t2_busy", busy, 1);
    sendByte(8'h00);
    recvRb(rb0);
    sendByte(8'hFF);
    recvRb(rb1);
    checkOutput("t2_rb0", rb0, 8'hA5);
    checkOutput("t2_rb1", rb1, 8'h3C);
    checkOutput("t2_head_seq", head_log, 16'hFF00);
    checkOutput("t2_chain", chain_a, 16'hFF00);
    checkOutput("t2_enable_count", en_cnt, 16);
    checkOutput("t2_done", done, 1);

    // Test 3: 12-bit chain, short final byte, extra byte refused
    sel = 1'b1;
    clearCount();
    doStart();
    sendByte(8'hFF);
    recvRb(rb0);
    sendByte(8'hFF);
    repeat (3) @(negedge clk);
    checkOutput("t3_fourth_shift_en", en, 1);
    @(negedge clk);
    checkOutput("t3_short_byte_end", en, 0);
    checkOutput("t3_rb_valid", rb_valid, 1);
    recvRb(rb1);
    checkOutput("t3_rb0", rb0, 8'hBC);
    checkOutput("t3_rb1", rb1, 8'h0A);
    checkOutput("t3_enable_count", en_cnt, 12);
    checkOutput("t3_chain", chain_b, 12'hFFF);
    checkOutput("t3_done", done, 1);
    n = 0;
    cmd_valid = 1'b1;
    cmd_data  = 8'h77;
    repeat (10) begin
      @(negedge clk);
      if (cmd_ready) n++;
    end
    cmd_valid = 1'b0;
    checkOutput("t3_extra_rejected", n, 0);
    checkOutput("t3_enable_count_after", en_cnt, 12);
    sel = 1'b0;
    @(negedge clk);

    // Test 4: readback backpressure stalls the load
    doStart();
    sendByte(8'h11);
    n = 0;
    while (!rb_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("t4_rb_arrives", n < 50, 1);
    ok = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (!(rb_valid === 1'b1 && rb_data === 8'h00 && cmd_ready === 1'b0 && en === 1'b0)) ok = 1'b0;
    end
    checkOutput("t4_stall_stable", ok, 1);
    recvRb(rb0);
    sendByte(8'h22);
    recvRb(rb1);
    checkOutput("t4_rb0", rb0, 8'h00);
    checkOutput("t4_rb1", rb1, 8'hFF);
    checkOutput("t4_chain", chain_a, 16'h2211);
    checkOutput("t4_done", done, 1);

    // Test 5: abort on the third shift cycle, then a clean reload
    doStart();
    sendByte(8'h5A);
    repeat (2) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    checkOutput("t5_enable_dropped", en, 0);
    checkOutput("t5_done", done, 0);
    checkOutput("t5_busy", busy, 0);
    checkOutput("t5_cmd_ready", cmd_ready, 0);
    checkOutput("t5_rb_valid", rb_valid, 0);
    abort = 1'b0;
    checkOutput("t5_partial_chain", chain_a, 16'h4442);
    clearCount();
    doLoad(8'hA5, 8'h3C, rb0, rb1);
    checkOutput("t5_rb0", rb0, 8'h42);
    checkOutput("t5_rb1", rb1, 8'h44);
    checkOutput("t5_enable_count", en_cnt, 16);
    checkOutput("t5_head_seq", head_log, 16'h3CA5);
    checkOutput("t5_chain", chain_a, 16'h3CA5);
    checkOutput("t5_done", done, 1);

    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    checkOutput("start_abort_done", done, 0);
    checkOutput("start_abort_busy", busy, 0);
    checkOutput("start_abort_ready", cmd_ready, 0);

    // Test 6: asynchronous reset mid-shift, then START while busy is ignored
    doStart();
    sendByte(8'h0F);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("t6_rst_enable", en, 0);
    checkOutput("t6_rst_busy", busy, 0);
    checkOutput("t6_rst_cmd_ready", cmd_ready, 0);
    checkOutput("t6_rst_rb_valid", rb_valid, 0);
    checkOutput("t6_rst_done", done, 0);
    checkOutput("t6_rst_head", head, 0);
    checkOutput("t6_rst_rb_data", rb_data, 0);
    #1 rst = 1'b0;
    @(negedge clk);
    clearCount();
    doStart();
    sendByte(8'hA5);
    doStart();
    recvRb(rb0);
    sendByte(8'h3C);
    recvRb(rb1);
    checkOutput("t6_enable_count", en_cnt, 16);
    checkOutput("t6_head_seq", head_log, 16'h3CA5);
    checkOutput("t6_chain", chain_a, 16'h3CA5);
    checkOutput("t6_done", done, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
